// File: rtl/vga_pattern_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// vga_pattern_sequencer_pkg
// Purpose : Shared command codes and reply-FSM state encoding for the VGA
//           pattern sequencer and its UART reply sender.
// Contents: CMD_* command byte codes, resp_state_t reply FSM states.
// ----------------------------------------------------------------------------
package vga_pattern_sequencer_pkg;

  // Received command bytes. Pattern selects are CMD_SEL_BASE + digit.
  localparam logic [7:0] CMD_SEL_BASE = 8'h30;
  localparam logic [7:0] CMD_SEL_LAST = 8'h39;
  localparam logic [7:0] CMD_AUTO     = 8'h41;
  localparam logic [7:0] CMD_STOP     = 8'h53;
  localparam logic [7:0] CMD_QUERY    = 8'h3F;

  // Reply sender handshake states.
  typedef enum logic [1:0] {
    RESP_IDLE      = 2'd0,
    RESP_SEND      = 2'd1,
    RESP_WAIT_DONE = 2'd2
  } resp_state_t;

endpackage

// File: rtl/vga_pattern_sequencer_uart_resp_sender.sv
// ----------------------------------------------------------------------------
// uart_resp_sender
// Purpose : Buffers one reply byte and hands it to UART_TX using the
//           tx_dv / tx_active / tx_done handshake. Replies arriving while the
//           holding slot is occupied are discarded and flagged.
// Ports   : clk_i, rst_n_i        clock, async active-low reset
//           req_i, req_byte_i     one-cycle reply request and its byte
//           tx_active_i           UART_TX busy
//           tx_done_i             UART_TX completion strobe
//           tx_dv_o, tx_byte_o    request strobe and byte to UART_TX
//           resp_drop_o           sticky flag, a reply was discarded
// ----------------------------------------------------------------------------
module uart_resp_sender
  import vga_pattern_sequencer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req_i,
  input  logic [7:0] req_byte_i,
  input  logic       tx_active_i,
  input  logic       tx_done_i,
  output logic       tx_dv_o,
  output logic [7:0] tx_byte_o,
  output logic       resp_drop_o
);

  resp_state_t state, state_next;
  logic        resp_valid;
  logic [7:0]  resp_byte;
  logic        load;

  // Reply FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= RESP_IDLE;
    else          state <= state_next;
  end

  // Next-state and handshake outputs. tx_dv_o is high only while in SEND,
  // which lasts exactly one cycle. Returning to IDLE on tx_done_i means the
  // next request cannot appear until at least one cycle later.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    tx_dv_o    = 1'b0;
    case (state)
      RESP_IDLE: begin
        if (resp_valid && !tx_active_i) begin
          load       = 1'b1;
          state_next = RESP_SEND;
        end
      end
      RESP_SEND: begin
        tx_dv_o    = 1'b1;
        state_next = RESP_WAIT_DONE;
      end
      RESP_WAIT_DONE: begin
        if (tx_done_i) state_next = RESP_IDLE;
      end
      default: state_next = RESP_IDLE;
    endcase
  end

  // Holding slot, output byte and drop flag. A request landing in the same
  // cycle the slot is emptied by the FSM is still accepted.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      resp_valid  <= 1'b0;
      resp_byte   <= 8'h00;
      tx_byte_o   <= 8'h00;
      resp_drop_o <= 1'b0;
    end else begin
      if (load) begin
        tx_byte_o  <= resp_byte;
        resp_valid <= 1'b0;
      end
      if (req_i) begin
        if (!resp_valid || load) begin
          resp_valid <= 1'b1;
          resp_byte  <= req_byte_i;
        end else begin
          resp_drop_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vga_pattern_sequencer.sv
// ----------------------------------------------------------------------------
// vga_pattern_sequencer
// Purpose : Command controller between UART_RX/UART_TX and the test pattern
//           generator. Decodes command bytes, applies pattern changes only at
//           the start of vertical blanking, auto-cycles patterns every
//           FRAMES_PER_PATTERN frames and returns a one-byte reply.
// Ports   : clk_i, rst_n_i          clock, async active-low reset
//           rx_dv_i, rx_byte_i      received byte strobe and data
//           vsync_i                 high during active rows, falls at blanking
//           tx_active_i, tx_done_i  UART_TX status
//           tx_dv_o, tx_byte_o      reply request and byte
//           pattern_o               committed pattern index
//           auto_mode_o             auto-cycle active
//           last_cmd_o              last received byte
//           resp_drop_o             sticky, a reply was discarded
// ----------------------------------------------------------------------------
module vga_pattern_sequencer
  import vga_pattern_sequencer_pkg::*;
#(
  parameter int          NUM_PATTERNS       = 6,
  parameter int          FRAMES_PER_PATTERN = 60,
  parameter logic [7:0]  ACK_BYTE           = 8'h4B,
  parameter logic [7:0]  NAK_BYTE           = 8'h21
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       rx_dv_i,
  input  logic [7:0] rx_byte_i,
  input  logic       vsync_i,
  input  logic       tx_active_i,
  input  logic       tx_done_i,
  output logic       tx_dv_o,
  output logic [7:0] tx_byte_o,
  output logic [3:0] pattern_o,
  output logic       auto_mode_o,
  output logic [7:0] last_cmd_o,
  output logic       resp_drop_o
);

  localparam int CNT_W = $clog2(FRAMES_PER_PATTERN + 1);

  logic             vsync_q;
  logic             frame_edge;
  logic [3:0]       pending;
  logic             pending_valid;
  logic [CNT_W-1:0] frame_cnt;

  logic             cmd_digit;
  logic             cmd_sel_ok;
  logic             cmd_auto;
  logic             cmd_stop;
  logic [3:0]       sel_index;
  logic [7:0]       reply_byte;

  // vsync_q resets low so a vsync_i already low at reset release is not
  // mistaken for the start of blanking.
  assign frame_edge = vsync_q & ~vsync_i;
  assign sel_index  = rx_byte_i[3:0];

  // Command decode and reply selection. A query reports the committed
  // pattern, not one still waiting for the next frame edge.
  always_comb begin
    cmd_digit  = (rx_byte_i >= CMD_SEL_BASE) && (rx_byte_i <= CMD_SEL_LAST);
    cmd_sel_ok = cmd_digit && (sel_index < 4'(NUM_PATTERNS));
    cmd_auto   = (rx_byte_i == CMD_AUTO);
    cmd_stop   = (rx_byte_i == CMD_STOP);
    reply_byte = NAK_BYTE;
    if (cmd_sel_ok || cmd_auto || cmd_stop) reply_byte = ACK_BYTE;
    else if (rx_byte_i == CMD_QUERY)        reply_byte = CMD_SEL_BASE + {4'h0, pattern_o};
  end

  // Pattern state. Frame-edge work (commit or auto advance) is written first
  // so a command arriving on the same edge overrides it: a new select
  // becomes pending for the following frame, and 'A' restarts the frame
  // count without advancing. Commit and auto advance never coincide because
  // a select clears auto mode and 'A' drops any pending select.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vsync_q       <= 1'b0;
      pattern_o     <= 4'd0;
      pending       <= 4'd0;
      pending_valid <= 1'b0;
      auto_mode_o   <= 1'b0;
      frame_cnt     <= '0;
      last_cmd_o    <= 8'h00;
    end else begin
      vsync_q <= vsync_i;
      if (frame_edge && pending_valid) begin
        pattern_o     <= pending;
        pending_valid <= 1'b0;
        frame_cnt     <= '0;
      end else if (frame_edge && auto_mode_o && !(rx_dv_i && cmd_auto)) begin
        if (frame_cnt == CNT_W'(FRAMES_PER_PATTERN - 1)) begin
          frame_cnt <= '0;
          pattern_o <= (pattern_o == 4'(NUM_PATTERNS - 1)) ? 4'd0 : pattern_o + 4'd1;
        end else begin
          frame_cnt <= frame_cnt + CNT_W'(1);
        end
      end
      if (rx_dv_i) begin
        last_cmd_o <= rx_byte_i;
        if (cmd_sel_ok) begin
          pending       <= sel_index;
          pending_valid <= 1'b1;
          auto_mode_o   <= 1'b0;
        end else if (cmd_auto) begin
          auto_mode_o   <= 1'b1;
          frame_cnt     <= '0;
          pending_valid <= 1'b0;
        end else if (cmd_stop) begin
          auto_mode_o   <= 1'b0;
        end
      end
    end
  end

  uart_resp_sender u_resp (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .req_i       (rx_dv_i),
    .req_byte_i  (reply_byte),
    .tx_active_i (tx_active_i),
    .tx_done_i   (tx_done_i),
    .tx_dv_o     (tx_dv_o),
    .tx_byte_o   (tx_byte_o),
    .resp_drop_o (resp_drop_o)
  );

endmodule
